// File: rtl/pio_edge_irq_in_pkg.sv
// Register map and parameter bounds shared by the edge-capturing input PIO,
// its bus interface and the testbench.
package pio_edge_pkg;

   localparam int ADDR_W    = 3;
   localparam int BUS_W     = 32;
   localparam int MAX_WIDTH = 32;
   localparam int MAX_CNT_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_DBTH = 3'd5;

endpackage

// File: rtl/pio_edge_irq_in_if.sv
// Avalon-MM slave bus of the input PIO: word address, active-low write strobe,
// registered read data.
interface pio_edge_irq_in_if;
   import pio_edge_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/pio_debounce_chan.sv
// One input channel: metastability synchroniser, threshold debouncer and
// rise/fall pulse generation on the debounced level.
module pio_debounce_chan #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_async,
   input  logic [CNT_W-1:0] db_thresh,
   output logic             db_q,
   output logic             rise,
   output logic             fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_W-1:0]       cnt;
   logic                   sync_out;
   logic                   differ;
   logic                   upd;

   assign sync_out = sync_r[SYNC_STAGES-1];
   assign differ   = (sync_out != db_q);
   // >= rather than == so a threshold lowered mid-count releases at once.
   assign upd      = differ && (cnt >= db_thresh);
   assign rise     = upd & sync_out;
   assign fall     = upd & ~sync_out;

   // NOTE: the synchroniser is a bare flop chain; any logic between stages
   // would defeat metastability settling.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
         cnt    <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in_async};
         if (!differ) begin
            cnt <= '0;
         end else if (upd) begin
            db_q <= sync_out;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pio_edge_irq_in.sv
// Parametrised Avalon-MM input PIO with per-channel debounce, rise/fall edge
// selection, write-1-to-clear edge capture and a masked level interrupt.
module pio_edge_irq_in
   import pio_edge_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] DB_RESET    = '0,
   parameter logic [WIDTH-1:0] RISE_RESET  = '1,
   parameter logic [WIDTH-1:0] FALL_RESET  = '0
) (
   input  logic             clk,
   input  logic             reset,
   pio_edge_irq_in_if.slave bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [CNT_W-1:0] db_thresh;
   logic [BUS_W-1:0] rd_next;
   logic             wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pio_debounce_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .in_async  (in_port[i]),
         .db_thresh (db_thresh),
         .db_q      (db_q[i]),
         .rise      (rise[i]),
         .fall      (fall[i])
      );
   end

   assign wr  = bus.chipselect & ~bus.write_n;
   assign ev  = (rise & rise_en) | (fall & fall_en);
   assign clr = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

   // Upper write-data bits have no destination for narrow configurations.
   assign unused_wdata = ^bus.writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en   <= RISE_RESET;
         fall_en   <= FALL_RESET;
         irq_mask  <= '0;
         db_thresh <= DB_RESET;
      end else if (wr) begin
         case (bus.address)
            ADDR_RISE: rise_en   <= bus.writedata[WIDTH-1:0];
            ADDR_FALL: fall_en   <= bus.writedata[WIDTH-1:0];
            ADDR_MASK: irq_mask  <= bus.writedata[WIDTH-1:0];
            ADDR_DBTH: db_thresh <= bus.writedata[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // An event in the same cycle as its clear wins, so no edge is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) edge_capture <= '0;
      else       edge_capture <= (edge_capture & ~clr) | ev;
   end

   // NOTE: every variable assigned in always_comb gets a default first so no
   // latch is inferred for unmapped addresses.
   always_comb begin
      rd_next = '0;
      case (bus.address)
         ADDR_DATA: rd_next = BUS_W'(db_q);
         ADDR_RISE: rd_next = BUS_W'(rise_en);
         ADDR_FALL: rd_next = BUS_W'(fall_en);
         ADDR_EDGE: rd_next = BUS_W'(edge_capture);
         ADDR_MASK: rd_next = BUS_W'(irq_mask);
         ADDR_DBTH: rd_next = BUS_W'(db_thresh);
         default:   rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= rd_next;
   end

   // Driven only from registers, so reset removes the interrupt asynchronously.
   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Directed and random stimulus for the input PIO, checked every cycle against
// a stable-duration reference model of the debounce and capture rules.
module tb_pio_edge_irq_in;
   import pio_edge_pkg::*;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   pio_edge_irq_in_if bus ();

   pio_edge_irq_in #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: sync_out is in_port delayed SYNC_STAGES samples; the
   // debounced level adopts a new value once it has been seen for
   // db_thresh+1 consecutive clock edges.
   logic [WIDTH-1:0] hist [SYNC_STAGES];
   int               run  [WIDTH];
   logic [WIDTH-1:0] m_prev_sync, m_db, m_rise_en, m_fall_en, m_mask, m_cap;
   logic [CNT_W-1:0] m_thresh;
   logic [31:0]      m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic m_irq();
      return |(m_cap & m_mask);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SYNC_STAGES; s++) hist[s] = '0;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
      m_prev_sync = '0;
      m_db        = '0;
      m_rise_en   = '1;
      m_fall_en   = '0;
      m_mask      = '0;
      m_cap       = '0;
      m_thresh    = '0;
      m_rd        = '0;
   endtask

   task automatic model_edge();
      logic [WIDTH-1:0] sync, rise, fall, ev, clr;
      logic             wr;
      sync = hist[SYNC_STAGES-1];
      rise = '0;
      fall = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync[i] == m_prev_sync[i]) begin
            if (run[i] < 1000000) run[i] = run[i] + 1;
         end else begin
            run[i] = 1;
         end
         if (sync[i] != m_db[i] && longint'(run[i]) >= longint'(m_thresh) + 1) begin
            if (sync[i]) rise[i] = 1'b1;
            else         fall[i] = 1'b1;
         end
      end
      case (bus.address)
         3'd0:    m_rd = 32'(m_db);
         3'd1:    m_rd = 32'(m_rise_en);
         3'd2:    m_rd = 32'(m_fall_en);
         3'd3:    m_rd = 32'(m_cap);
         3'd4:    m_rd = 32'(m_mask);
         3'd5:    m_rd = 32'(m_thresh);
         default: m_rd = 32'd0;
      endcase
      wr  = bus.chipselect && !bus.write_n;
      ev  = (rise & m_rise_en) | (fall & m_fall_en);
      clr = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
      m_cap = (m_cap & ~clr) | ev;
      m_db  = m_db ^ (rise | fall);
      if (wr) begin
         case (bus.address)
            3'd1: m_rise_en = bus.writedata[WIDTH-1:0];
            3'd2: m_fall_en = bus.writedata[WIDTH-1:0];
            3'd4: m_mask    = bus.writedata[WIDTH-1:0];
            3'd5: m_thresh  = bus.writedata[CNT_W-1:0];
            default: ;
         endcase
      end
      m_prev_sync = sync;
      for (int s = SYNC_STAGES - 1; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = in_port;
   endtask

   // One clock: model advances on the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("readdata", bus.readdata, m_rd);
      check("irq", 32'(irq), 32'(m_irq()));
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      step();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      step();
      d = bus.readdata;
   endtask

   logic [31:0] rd;

   initial begin
      reset          = 1'b1;
      in_port        = '0;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_readdata", bus.readdata, 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      read_reg(3'd1, rd); check("reset_rise_en", rd, 32'h0000_00ff);
      read_reg(3'd2, rd); check("reset_fall_en", rd, 32'd0);
      read_reg(3'd5, rd); check("reset_db_thresh", rd, 32'd0);

      // Unfiltered rising edge on bit 0 lands in capture at edge 2.
      bus.address = 3'd3;
      in_port     = 8'h01;
      steps(3);
      check("t1_cap_before_edge2", bus.readdata, 32'd0);
      step();
      check("t1_cap_after_edge2", bus.readdata, 32'h01);
      check("t1_irq_masked", 32'(irq), 32'd0);
      read_reg(3'd0, rd); check("t1_data", rd, 32'h01);
      bus_write(3'd3, 32'h01);

      // Falling edge with threshold 10: short glitch rejected, long low captured.
      in_port = 8'h09;
      steps(4);
      bus_write(3'd3, 32'hff);
      bus_write(3'd2, 32'h08);
      bus_write(3'd5, 32'd10);
      bus.address = 3'd3;
      in_port = 8'h01;
      steps(5);
      in_port = 8'h09;
      steps(20);
      check("t2_glitch_no_capture", bus.readdata, 32'd0);
      in_port = 8'h01;
      steps(13);
      check("t2_cap_before_edge12", bus.readdata, 32'd0);
      step();
      check("t2_cap_after_edge12", bus.readdata, 32'h08);
      in_port = 8'h09;
      steps(20);

      // Masked interrupt and write-1-to-clear.
      bus_write(3'd5, 32'd0);
      in_port = 8'h08;
      steps(5);
      bus_write(3'd3, 32'hff);
      in_port = 8'h0d;
      steps(5);
      read_reg(3'd3, rd); check("t3_capture", rd, 32'h05);
      bus_write(3'd4, 32'h04);
      check("t3_irq_set", 32'(irq), 32'd1);
      bus_write(3'd3, 32'h04);
      check("t3_irq_cleared", 32'(irq), 32'd0);
      read_reg(3'd3, rd); check("t3_capture_after_w1c", rd, 32'h01);

      // Rising event on bit 1 coincides with its clear.
      in_port = 8'h0f;
      steps(2);
      bus_write(3'd3, 32'h02);
      read_reg(3'd3, rd); check("t4_event_beats_clear", rd, 32'h03);

      // Reset in the middle of a debounce count with a pending interrupt.
      bus_write(3'd4, 32'hff);
      check("t5_irq_before_reset", 32'(irq), 32'd1);
      bus_write(3'd5, 32'd10);
      in_port = 8'h1f;
      steps(9);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("t5_irq_async_drop", 32'(irq), 32'd0);
      check("t5_readdata_reset", bus.readdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_write(3'd5, 32'd10);
      bus.address = 3'd3;
      steps(30);

      // Threshold readback and unmapped addresses.
      bus_write(3'd5, 32'h0000_1234);
      read_reg(3'd5, rd); check("t6_dbth_readback", rd, 32'h0000_1234);
      bus_write(3'd6, 32'hdead_beef);
      bus_write(3'd0, 32'hffff_ffff);
      read_reg(3'd6, rd); check("t6_addr6_zero", rd, 32'd0);
      read_reg(3'd7, rd); check("t6_addr7_zero", rd, 32'd0);
      bus_write(3'd5, 32'd2);

      // Random inputs and bus traffic, compared against the model each cycle.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 4) == 0) begin
            int b;
            b = $urandom_range(0, WIDTH - 1);
            in_port[b] = ~in_port[b];
         end
         bus.address    = 3'($urandom_range(0, 7));
         bus.chipselect = 1'($urandom_range(0, 1));
         bus.write_n    = ($urandom_range(0, 4) != 0);
         bus.writedata  = (bus.address == 3'd5) ? 32'($urandom_range(0, 6)) : 32'($urandom);
         step();
      end
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      steps(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
